fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Instruction-fetch front end of the 19-bit CPU: produces the Op/funct5 fields the control unit decodes, and consumes its Branch/Jump/Call/Ret outputs to sequence the PC.
- Holds the PC, talks to instruction memory with a req/ready handshake, and presents one instruction at a time downstream with a valid/ready handshake.
- Contains a hardware return-address stack for Call/Ret.

Parameters:
ADDR_W, 19, PC and instruction-memory address width
INSTR_W, 19, instruction width
STACK_DEPTH, 8, return-stack entries (power of two, ≥2)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  ADDR_W  fetch address (= PC)
imem_ready  input  1  imem_rdata valid this cycle
imem_rdata  input  INSTR_W  fetched instruction
instr_valid  output  1  Instr/Op/funct5/pc_out valid
instr_ready  input  1  downstream accepts instruction
Instr  output  INSTR_W  held instruction
Op  output  5  Instr[18:14]
funct5  output  5  Instr[4:0]
pc_out  output  ADDR_W  address of held instruction
Branch  input  1  from control unit, for held instruction
Jump  input  1  from control unit
Call  input  1  from control unit
Ret  input  1  from control unit
branch_taken  input  1  branch condition result (e.g. Zero)
target_addr  input  ADDR_W  branch/jump/call target
flush  input  1  synchronous redirect to flush_addr
flush_addr  input  ADDR_W  redirect address
stack_overflow  output  1  sticky: Call with full stack
stack_underflow  output  1  sticky: Ret with empty stack

Behaviour:
- Reset (rst=0, async): PC=0, state IDLE, imem_req=0, instr_valid=0, Instr=0, pc_out=0, stack empty (count 0), both sticky flags 0. Any outstanding fetch is abandoned; imem_ready is ignored outside REQ.
- FSM:
  - IDLE: one cycle, then REQ.
  - REQ: imem_req=1, imem_addr=PC. On imem_ready: Instr←imem_rdata, pc_out←PC, go HOLD.
  - HOLD: instr_valid=1; Instr/Op/funct5/pc_out stable while instr_ready=0. On instr_ready (accept): compute next PC, go REQ.
- Throughput: 1 instruction per 2 cycles minimum. Fetch latency = imem wait cycles + 1.
- Control inputs are sampled only on the accept cycle (instr_valid & instr_ready).
- Next-PC priority on accept:
  1. Ret: if count>0, PC←top, pop. If count=0, stack_underflow←1, PC←pc_out+1.
  2. Call: PC←target_addr; push pc_out+1. If count=STACK_DEPTH, the push is dropped, stack_overflow←1, and the redirect still occurs.
  3. Jump: PC←target_addr.
  4. Branch & branch_taken: PC←target_addr.
  5. Otherwise: PC←pc_out+1.
- PC increment is modulo 2^ADDR_W; all-ones wraps to 0.
- flush (any state): next cycle PC←flush_addr, instr_valid=0, state REQ; any in-flight imem response that cycle is discarded. flush overrides a simultaneous accept; control inputs are ignored that cycle and the stack is unchanged.
- Stack: LIFO, pointer wraps only within 0..STACK_DEPTH-1. Simultaneous push+pop is impossible by priority.
- Sticky flags clear only on reset.

Test Plan:
- Reset, imem_ready tied 1, instr_ready 1, no control inputs → imem_addr 0,1,2,3 on successive REQ cycles; instr_valid every 2nd cycle; pc_out tracks.
- Hold instr_ready=0 for 5 cycles in HOLD with Instr=0x5A5A5 → outputs stable; Op=5'h16, funct5=5'h05; no new imem_req.
- At pc_out=0x10, Call with target 0x200 → next fetch 0x200. Later Ret at 0x205 → next fetch 0x11; count returns to 0.
- 9 nested Calls with STACK_DEPTH=8 → stack_overflow=1 after the 9th; 8 Rets return in LIFO order; 9th Ret → stack_underflow=1, fetch pc_out+1.
- Branch=1 with branch_taken=0 → PC+1; with branch_taken=1 → target. Jump+Branch both set → target (Jump). PC=0x7FFFF, plain instruction → next fetch 0x00000.
- flush asserted in REQ while imem_ready=1, flush_addr=0x300 → response dropped, next imem_addr=0x300. rst deasserted-to-asserted mid-HOLD → instr_valid=0 immediately, stack empty, refetch from 0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch front end: PC sequencing, imem handshake,
// downstream valid/ready hold register and return-address stack.
`timescale 1ns/1ps
module fetch_sequencer #(
    parameter int ADDR_W      = 19,
    parameter int INSTR_W     = 19,
    parameter int STACK_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] Instr,
    output logic [4:0]         Op,
    output logic [4:0]         funct5,
    output logic [ADDR_W-1:0]  pc_out,
    input  logic               Branch,
    input  logic               Jump,
    input  logic               Call,
    input  logic               Ret,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  target_addr,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  flush_addr,
    output logic               stack_overflow,
    output logic               stack_underflow
);

    localparam int PW = $clog2(STACK_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD
    } state_t;

    state_t state, state_n;

    logic [ADDR_W-1:0]  pc, pc_n;
    logic [ADDR_W-1:0]  pc_hold;
    logic [ADDR_W-1:0]  seq_pc;
    logic [ADDR_W-1:0]  top;
    logic [INSTR_W-1:0] instr_q;
    logic [CW-1:0]      cnt, cnt_n;
    logic [PW-1:0]      top_idx;
    logic               full, empty;
    logic               push, load;
    logic               ovf_set, unf_set;
    logic               ovf_q, unf_q;

    logic [ADDR_W-1:0]  stack [STACK_DEPTH];

    assign seq_pc  = pc_hold + ADDR_W'(1);
    assign full    = (cnt == CW'(STACK_DEPTH));
    assign empty   = (cnt == '0);
    // Low bits minus one also lands on DEPTH-1 when the stack is full.
    assign top_idx = cnt[PW-1:0] - PW'(1);
    assign top     = stack[top_idx];

    assign imem_req        = (state == REQ);
    assign imem_addr       = pc;
    assign instr_valid     = (state == HOLD);
    assign Instr           = instr_q;
    assign Op              = instr_q[INSTR_W-1 -: 5];
    assign funct5          = instr_q[4:0];
    assign pc_out          = pc_hold;
    assign stack_overflow  = ovf_q;
    assign stack_underflow = unf_q;

    always_comb begin
        state_n = state;
        pc_n    = pc;
        cnt_n   = cnt;
        push    = 1'b0;
        load    = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (flush) begin
            state_n = REQ;
            pc_n    = flush_addr;
        end else begin
            unique case (state)
                IDLE: state_n = REQ;
                REQ: begin
                    if (imem_ready) begin
                        load    = 1'b1;
                        state_n = HOLD;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        state_n = REQ;
                        if (Ret) begin
                            if (!empty) begin
                                pc_n  = top;
                                cnt_n = cnt - CW'(1);
                            end else begin
                                unf_set = 1'b1;
                                pc_n    = seq_pc;
                            end
                        end else if (Call) begin
                            pc_n = target_addr;
                            if (full) begin
                                ovf_set = 1'b1;
                            end else begin
                                push  = 1'b1;
                                cnt_n = cnt + CW'(1);
                            end
                        end else if (Jump || (Branch && branch_taken)) begin
                            pc_n = target_addr;
                        end else begin
                            pc_n = seq_pc;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            pc      <= '0;
            pc_hold <= '0;
            instr_q <= '0;
            cnt     <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            cnt   <= cnt_n;
            if (load) begin
                instr_q <= imem_rdata;
                pc_hold <= pc;
            end
            if (ovf_set) ovf_q <= 1'b1;
            if (unf_set) unf_q <= 1'b1;
        end
    end

    // Entries above cnt are dead, so the storage needs no reset.
    always_ff @(posedge clk) begin
        if (push) stack[cnt[PW-1:0]] <= seq_pc;
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized scoreboard bench for fetch_sequencer against an
// abstract fetch-stream model with a queue-based return stack.
`timescale 1ns/1ps
module tb_fetch_sequencer;

    localparam int AW    = 19;
    localparam int IW    = 19;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ready;
    logic [IW-1:0] imem_rdata;
    logic          instr_valid;
    logic          instr_ready;
    logic [IW-1:0] Instr;
    logic [4:0]    Op;
    logic [4:0]    funct5;
    logic [AW-1:0] pc_out;
    logic          Branch, Jump, Call, Ret, branch_taken;
    logic [AW-1:0] target_addr;
    logic          flush;
    logic [AW-1:0] flush_addr;
    logic          stack_overflow, stack_underflow;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    int stall = 0;

    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] stk[$];
    logic          m_ovf, m_unf;
    logic          hold_pend;
    logic [AW-1:0] h_pc;
    logic [IW-1:0] h_in;

    fetch_sequencer #(
        .ADDR_W(AW), .INSTR_W(IW), .STACK_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .Instr(Instr), .Op(Op), .funct5(funct5), .pc_out(pc_out),
        .Branch(Branch), .Jump(Jump), .Call(Call), .Ret(Ret),
        .branch_taken(branch_taken), .target_addr(target_addr),
        .flush(flush), .flush_addr(flush_addr),
        .stack_overflow(stack_overflow),
        .stack_underflow(stack_underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] mem_f(logic [AW-1:0] a);
        logic [31:0] t;
        t = {13'd0, a} * 32'h9E37 + 32'h1234;
        return t[IW-1:0] ^ a;
    endfunction

    assign imem_rdata = mem_f(imem_addr);

    function automatic logic rnd(int pct);
        return $urandom_range(99) < pct;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [AW-1:0] e, n;
        logic [IW-1:0] ei;
        if (!rst) begin
            exp_q.delete();
            exp_q.push_back('0);
            stk.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            hold_pend = 1'b0;
            stall = 0;
        end else begin
            chk("ovf_flag", 32'(stack_overflow), 32'(m_ovf));
            chk("unf_flag", 32'(stack_underflow), 32'(m_unf));
            chk("req_in_hold", 32'(imem_req & instr_valid), 0);
            if (imem_req) begin
                if (exp_q.size() == 0) chk("addr_queue_empty", 0, 1);
                else chk("imem_addr", 32'(imem_addr), 32'(exp_q[0]));
            end
            if (hold_pend) begin
                chk("hold_valid", 32'(instr_valid), 1);
                chk("hold_pc", 32'(pc_out), 32'(h_pc));
                chk("hold_instr", 32'(Instr), 32'(h_in));
            end
            hold_pend = instr_valid && !instr_ready && !flush;
            h_pc = pc_out;
            h_in = Instr;
            if (flush) begin
                exp_q.delete();
                exp_q.push_back(flush_addr);
                stall++;
            end else if (instr_valid && instr_ready) begin
                acc_cnt++;
                stall = 0;
                if (exp_q.size() == 0) begin
                    chk("accept_queue_empty", 0, 1);
                end else begin
                    e  = exp_q.pop_front();
                    ei = mem_f(e);
                    chk("pc_out", 32'(pc_out), 32'(e));
                    chk("instr", 32'(Instr), 32'(ei));
                    chk("op", 32'(Op), 32'(ei[18:14]));
                    chk("funct5", 32'(funct5), 32'(ei[4:0]));
                    if (Ret) begin
                        if (stk.size() > 0) n = stk.pop_back();
                        else begin m_unf = 1'b1; n = e + 1'b1; end
                    end else if (Call) begin
                        n = target_addr;
                        if (stk.size() < DEPTH) stk.push_back(e + 1'b1);
                        else m_ovf = 1'b1;
                    end else if (Jump || (Branch && branch_taken)) begin
                        n = target_addr;
                    end else begin
                        n = e + 1'b1;
                    end
                    exp_q.push_back(n);
                end
            end else begin
                stall++;
            end
            if (stall > 200) begin
                chk("progress_timeout", 0, 1);
                stall = 0;
            end
        end
    end

    task automatic run_phase(int n, int pm, int pi, int pc, int pr,
                             int pj, int pb, int pf);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            imem_ready   = rnd(pm);
            instr_ready  = rnd(pi);
            Call         = rnd(pc);
            Ret          = rnd(pr);
            Jump         = rnd(pj);
            Branch       = rnd(pb);
            branch_taken = rnd(50);
            flush        = rnd(pf);
            target_addr  = AW'($urandom);
            flush_addr   = AW'($urandom);
            if (rnd(10)) target_addr = 19'h7FFFF;
        end
    endtask

    task automatic quiet();
        Call = 0; Ret = 0; Jump = 0; Branch = 0; branch_taken = 0;
        flush = 0;
    endtask

    initial begin
        int a0, w;
        rst = 1'b0;
        imem_ready = 0; instr_ready = 0;
        target_addr = '0; flush_addr = '0;
        quiet();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(imem_req), 0);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_instr", 32'(Instr), 0);
        chk("rst_pc_out", 32'(pc_out), 0);
        chk("rst_addr", 32'(imem_addr), 0);
        chk("rst_flags", 32'({stack_overflow, stack_underflow}), 0);
        @(posedge clk); #3;
        rst = 1'b1;

        a0 = acc_cnt;
        run_phase(40, 100, 100, 0, 0, 0, 0, 0);
        w = acc_cnt - a0;
        chk("throughput", 32'(w >= 18 && w <= 20), 1);

        run_phase(400, 60, 60, 10, 10, 10, 20, 3);
        run_phase(250, 70, 80, 80, 5, 5, 5, 0);
        run_phase(300, 70, 80, 3, 80, 5, 5, 0);

        @(posedge clk); #1;
        quiet();
        imem_ready = 1; instr_ready = 1;
        flush = 1; flush_addr = 19'h7FFFE;
        run_phase(20, 100, 100, 0, 0, 0, 0, 0);

        run_phase(300, 50, 50, 15, 15, 10, 20, 5);

        @(posedge clk); #1;
        quiet();
        instr_ready = 0;
        imem_ready = 1;
        w = 0;
        while (!instr_valid && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        chk("valid_before_rst", 32'(instr_valid), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_valid", 32'(instr_valid), 0);
        chk("midrst_req", 32'(imem_req), 0);
        chk("midrst_pc_out", 32'(pc_out), 0);
        chk("midrst_flags", 32'({stack_overflow, stack_underflow}), 0);
        @(posedge clk); #3;
        rst = 1'b1;
        run_phase(200, 60, 60, 20, 20, 10, 20, 0);

        @(posedge clk); #1;
        quiet();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
